mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive data grants allowed while if_req is pending (fairness build only).
REQ-002 Parameter TIMEOUT, default 255: max cycles waiting for ram_ack before aborting.
REQ-003 Clocking: one clock g_clk; reset g_rst is asynchronous, active-high.
REQ-004 g_clk  in  1  system clock, rising edge.
REQ-005 g_rst  in  1  asynchronous active-high reset.
REQ-006 if_req  in  1  fetch request; held with if_addr until if_ready.
REQ-007 if_addr  in  32  fetch word address.
REQ-008 if_rdata  out  32  fetched instruction, valid while if_ready is high.
REQ-009 if_ready  out  1  one-cycle fetch completion pulse.
REQ-010 mem_req  in  1  data request; held with mem_we/mem_addr/mem_wdata until mem_ready.
REQ-011 mem_we  in  1  1 = write, 0 = read.
REQ-012 mem_addr, mem_wdata  in  32 each  data address and write data.
REQ-013 mem_rdata  out  32  load data, valid while mem_ready is high.
REQ-014 mem_ready  out  1  one-cycle data completion pulse.
REQ-015 ram_addr, ram_wdata  out  32 each  shared memory address and write data.
REQ-016 ram_re, ram_we  out  1 each  shared memory read and write strobes.
REQ-017 ram_rdata  in  32  shared memory read data.
REQ-018 ram_ack  in  1  memory completion, sampled on g_clk.
REQ-019 bus_err  out  1  pulses together with the ready pulse of a timed-out transfer.

Function
REQ-020 States SHALL be IDLE, IF_XFER, D_XFER and DONE.
REQ-021 IDLE: mem_req -> D_XFER; otherwise if_req -> IF_XFER; neither -> stay in IDLE.
REQ-022 On entry to an XFER state, ram_addr/ram_wdata/ram_re/ram_we SHALL be registered from the granted port and held stable until exit.
REQ-023 For a fetch, ram_re=1 and ram_we=0.
REQ-024 For a data access, ram_we=mem_we and ram_re=~mem_we.
REQ-025 ram_ack sampled high in XFER -> go to DONE; drop the ram strobes; capture ram_rdata into the granted port's rdata on reads; pulse that port's ready in DONE.
REQ-026 Latency: request seen in IDLE at cycle 0, ram strobes at cycle 1, ack at cycle N (N>=1), ready at cycle N+1.
REQ-027 DONE SHALL last exactly one cycle, then IDLE; the request is not re-sampled during the ready cycle, so no double grant occurs.
REQ-028 On a write, mem_rdata SHALL keep its previous value.
REQ-029 Each rdata SHALL hold its value until the next read completion on that port.
REQ-030 Timeout: an 8-bit cycle counter clears on XFER entry; at TIMEOUT cycles without ack, go to DONE with bus_err=1 and rdata=0.
REQ-031 A requester that drops req mid-transfer SHALL NOT abort the transfer; it completes and its ready pulse is still issued.
REQ-032 ram_ack seen in IDLE or DONE SHALL be ignored.

Reset
REQ-033 Asserting g_rst SHALL immediately force IDLE and zero every output, rdata registers and all counters, abandoning any in-flight transfer.
REQ-034 The first grant SHALL occur no earlier than the first rising edge after g_rst is deasserted.

Configuration
REQ-035 With ARB_FAIRNESS_EN defined, a 2-bit counter SHALL count consecutive data grants made while if_req is high.
REQ-036 With ARB_FAIRNESS_EN, when that counter reaches STARVE_LIMIT the next IDLE arbitration SHALL grant IF, and the counter SHALL clear on any IF grant.
REQ-037 Without ARB_FAIRNESS_EN, data SHALL have strict priority and no counter SHALL exist.

Structure
REQ-038 State encodings, GRANT_IF/GRANT_D codes and the default TIMEOUT SHALL be defined in the shared constants.v.
REQ-039 The timeout counter SHALL be sub-module mem_arb_timer (inputs clear/enable; output expired).

Verification
REQ-040 if_req=1, if_addr=0x00000010, ram_ack on the 1st strobe cycle, ram_rdata=0x8C010004 -> if_ready pulses at cycle 2 with if_rdata=0x8C010004; ram_re=1 at cycle 1 only.
REQ-041 if_req and mem_req (read, 0x100) raised in the same cycle -> data served first; IF is granted in the IDLE cycle after DONE; exactly one ready per port.
REQ-042 Write mem_addr=0x200, mem_wdata=0xCAFEBABE, ack after 3 cycles -> ram_we=1 for 3 cycles, mem_ready at cycle 4, mem_rdata unchanged.
REQ-043 ram_ack never asserted -> after 255 strobe cycles, ready and bus_err pulse together with rdata=0, then IDLE.
REQ-044 g_rst asserted in D_XFER -> all outputs 0 asynchronously, no ready pulse; after release a new request completes normally.
REQ-045 ARB_FAIRNESS_EN, mem_req held high continuously with if_req high -> IF granted after 3 data grants; without the macro, IF is never granted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the mem_arbiter slice: FSM encoding, grant codes and defaults.
// The optional IF-starvation guard is enabled with ARB_FAIRNESS_EN.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_XFER = 2'd1,
        D_XFER  = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

    localparam int DEFAULT_TIMEOUT      = 255;
    localparam int DEFAULT_STARVE_LIMIT = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and shared RAM port of the arbiter, bundled as one interface.
// Handshake: a requester raises req with its payload and holds both until the one-cycle
// ready pulse; rdata is valid in that cycle and held until the next read on the port.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    logic        bus_err;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
        output if_rdata, if_ready, mem_rdata, mem_ready, ram_addr, ram_wdata, ram_re, ram_we,
               bus_err
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
        input  if_rdata, if_ready, mem_rdata, mem_ready, ram_addr, ram_wdata, ram_re, ram_we,
               bus_err
    );
endinterface

// File: rtl/mem_arb_timer.sv
// 8-bit wait counter for a RAM transfer; expired is high in the TIMEOUT-th enabled cycle.
import mem_arbiter_pkg::*;

module mem_arb_timer #(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic g_clk,
    input  logic g_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = enable && !clear && (count == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared RAM; data wins unless ARB_FAIRNESS_EN
// is defined, in which case IF is forced through after STARVE_LIMIT back-to-back data grants.
import mem_arbiter_pkg::*;

module mem_arbiter #(
`ifdef ARB_FAIRNESS_EN
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
`endif
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         g_clk,
    input  logic         g_rst,
    mem_arbiter_if.slave bus,
    output state_t       dbg_state
);
    state_t      state, next_state;
    grant_t      idle_grant;
    logic        pick_data, idle_take, in_xfer, xfer_end, expired;
    logic [31:0] ram_addr_q, ram_wdata_q, if_rdata_q, mem_rdata_q;
    logic        ram_re_q, ram_we_q, if_ready_q, mem_ready_q, bus_err_q;

`ifdef ARB_FAIRNESS_EN
    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);
    logic [1:0] starve_cnt;

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE && idle_take) begin
            if (idle_grant == GRANT_IF || !bus.if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 2'd3) begin
                starve_cnt <= starve_cnt + 2'd1;
            end
        end
    end

    assign pick_data = bus.mem_req && !(bus.if_req && starve_cnt >= STARVE_MAX);
`else
    assign pick_data = bus.mem_req;
`endif

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .g_clk  (g_clk),
        .g_rst  (g_rst),
        .clear  (!in_xfer),
        .enable (in_xfer),
        .expired(expired)
    );

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration only happens in IDLE; DONE always falls back to IDLE, so the ready
    // cycle never re-samples a request.
    always_comb begin
        idle_grant = pick_data ? GRANT_D : GRANT_IF;
        idle_take  = pick_data || bus.if_req;
        in_xfer    = (state == IF_XFER) || (state == D_XFER);
        xfer_end   = in_xfer && (bus.ram_ack || expired);
        next_state = state;
        case (state)
            IDLE:    if (idle_take) next_state = (idle_grant == GRANT_D) ? D_XFER : IF_XFER;
            IF_XFER,
            D_XFER:  if (xfer_end) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            if (state == IDLE && idle_take) begin
                if (idle_grant == GRANT_D) begin
                    ram_addr_q  <= bus.mem_addr;
                    ram_wdata_q <= bus.mem_wdata;
                    ram_re_q    <= ~bus.mem_we;
                    ram_we_q    <= bus.mem_we;
                end else begin
                    ram_addr_q  <= bus.if_addr;
                    ram_wdata_q <= '0;
                    ram_re_q    <= 1'b1;
                    ram_we_q    <= 1'b0;
                end
            end
            // A timed-out read returns zero; a write never disturbs mem_rdata.
            if (xfer_end) begin
                ram_re_q  <= 1'b0;
                ram_we_q  <= 1'b0;
                bus_err_q <= ~bus.ram_ack;
                if (state == IF_XFER) begin
                    if_ready_q <= 1'b1;
                    if_rdata_q <= bus.ram_ack ? bus.ram_rdata : '0;
                end else begin
                    mem_ready_q <= 1'b1;
                    if (ram_re_q) mem_rdata_q <= bus.ram_ack ? bus.ram_rdata : '0;
                end
            end
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.bus_err   = bus_err_q;
    assign dbg_state     = state;
endmodule
